// File: rtl/onehot_pkg.sv
// onehot_pkg
//   Shared types and constants for the one-hot word transmitter.
//   - walk_dir_e     : rotate direction of the hot bit (DIR_UP toward MSB, DIR_DOWN toward LSB)
//   - walker_state_e : transmitter state (IDLE emits nothing, ACTIVE presents beats)
//   - DEFAULT_DATA_WIDTH : default width of the one-hot output word
package onehot_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } walk_dir_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } walker_state_e;

endpackage : onehot_pkg

// File: rtl/onehot_bin2oh.sv
// onehot_bin2oh
//   Combinational binary -> one-hot decoder with saturation. Indices beyond the
//   top bit clamp to DATA_WIDTH-1 so the decoded word is always exactly one-hot.
// Ports
//   idx      in   IDX_W       binary index
//   idx_sat  out  IDX_W       index after clamping to DATA_WIDTH-1
//   oh       out  DATA_WIDTH  one-hot decode of idx_sat
module onehot_bin2oh
    import onehot_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int IDX_W     = $clog2(DATA_WIDTH)
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [IDX_W-1:0]      idx_sat,
    output logic [DATA_WIDTH-1:0] oh
);

    // Compare in one extra bit so the clamp test is never a constant
    // comparison when DATA_WIDTH is a power of two.
    logic [IDX_W:0] idx_ext;
    assign idx_ext = {1'b0, idx};

    assign idx_sat = (idx_ext > (IDX_W+1)'(DATA_WIDTH - 1)) ? IDX_W'(DATA_WIDTH - 1) : idx;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_dec
            assign oh[gi] = (idx_sat == IDX_W'(gi));
        end
    endgenerate

endmodule : onehot_bin2oh

// File: rtl/onehot_walker.sv
// onehot_walker
//   Transmit side of the one-hot word interface. A load presents 1<<load_idx;
//   each transferred beat with step=1 rotates the hot bit one place (dir=0 toward
//   MSB, dir=1 toward LSB), wrapping end-around. dout is all-zero while idle.
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   load_valid/load_ready    load handshake, load_idx is the binary index to load
//   dir, step, stop          walk direction, advance-on-transfer, return to idle
//   dout/dout_valid/dout_ready  one-hot beat stream
//   dout_idx                 binary index of the hot bit (0 when idle)
//   wrap                     dout was produced by an end-around rotate
//   err                      (only with ONEHOT_WALKER_SELFCHECK_EN) sticky flag set when
//                            dout is malformed for its valid state
// Build option
//   ONEHOT_WALKER_SELFCHECK_EN : adds the err port and its checker.
module onehot_walker
    import onehot_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int IDX_W     = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic                  dir,
    input  logic                  step,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [IDX_W-1:0]      dout_idx,
    output logic                  wrap
`ifdef ONEHOT_WALKER_SELFCHECK_EN
    ,
    output logic                  err
`endif
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_WIDTH - 1);

    walker_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_q, wrap_d;

    logic [DATA_WIDTH-1:0] load_oh;
    logic [IDX_W-1:0]      load_idx_sat;
    walk_dir_e             dir_e;
    logic                  load_acc;
    logic                  xfer;

    onehot_bin2oh #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bin2oh (
        .idx     (load_idx),
        .idx_sat (load_idx_sat),
        .oh      (load_oh)
    );

    assign dir_e      = walk_dir_e'(dir);
    assign dout_valid = (state_q == ACTIVE);
    // Loads are refused only while a presented beat is stalled, so a load can
    // never silently drop a beat the consumer has not taken.
    assign load_ready = !(dout_valid && !dout_ready);
    assign load_acc   = load_valid && load_ready;
    assign xfer       = dout_valid && dout_ready;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        if (stop) begin
            state_d = IDLE;
            dout_d  = '0;
            idx_d   = '0;
            wrap_d  = 1'b0;
        end else if (load_acc) begin
            state_d = ACTIVE;
            dout_d  = load_oh;
            idx_d   = load_idx_sat;
            wrap_d  = 1'b0;
        end else if (xfer && step) begin
            case (dir_e)
                DIR_UP: begin
                    dout_d = {dout_q[DATA_WIDTH-2:0], dout_q[DATA_WIDTH-1]};
                    wrap_d = (idx_q == IDX_TOP);
                    idx_d  = (idx_q == IDX_TOP) ? '0 : idx_q + IDX_W'(1);
                end
                default: begin
                    dout_d = {dout_q[0], dout_q[DATA_WIDTH-1:1]};
                    wrap_d = (idx_q == '0);
                    idx_d  = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
                end
            endcase
        end
        // A transfer with step=0 re-presents the same word, so wrap is kept.
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            dout_q  <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout     = dout_q;
    assign dout_idx = idx_q;
    assign wrap     = wrap_q;

`ifdef ONEHOT_WALKER_SELFCHECK_EN
    logic err_q, err_d;
    logic bad_word;

    assign bad_word = dout_valid ? ($countones(dout_q) != 1) : (dout_q != '0);

    always_comb begin
        err_d = err_q | bad_word;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule : onehot_walker

// File: tb/tb_onehot_walker.sv
// tb_onehot_walker
//   Directed vectors for onehot_walker at DATA_WIDTH=32 with hand-computed
//   expected words, indices and flags.
module tb_onehot_walker;

    localparam int DW    = 32;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             load_valid;
    logic             load_ready;
    logic [IDX_W-1:0] load_idx;
    logic             dir;
    logic             step;
    logic             stop;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [IDX_W-1:0] dout_idx;
    logic             wrap;
`ifdef ONEHOT_WALKER_SELFCHECK_EN
    logic             err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    onehot_walker #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .dir        (dir),
        .step       (step),
        .stop       (stop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .wrap       (wrap)
`ifdef ONEHOT_WALKER_SELFCHECK_EN
        ,
        .err        (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic v,
                           input logic [4:0] i, input logic w);
        chk({tag, ".dout"}, dout, d);
        chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
        chk({tag, ".idx"}, 32'(dout_idx), 32'(i));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        resetn = 1'b0; load_valid = 1'b0; load_idx = '0; dir = 1'b0;
        step = 1'b0; stop = 1'b0; dout_ready = 1'b0;

        // 1. reset
        tick(); tick();
        chk_out("rst", 32'h0, 1'b0, 5'd0, 1'b0);
        chk("rst.load_ready", 32'(load_ready), 32'd1);
`ifdef ONEHOT_WALKER_SELFCHECK_EN
        chk("rst.err", 32'(err), 32'd0);
`endif

        // 2. load 2 then walk up
        resetn = 1'b1; load_valid = 1'b1; load_idx = 5'd2; dout_ready = 1'b1; step = 1'b1; dir = 1'b0;
        tick(); chk_out("ld2", 32'h4, 1'b1, 5'd2, 1'b0);
        load_valid = 1'b0;
        tick(); chk_out("up1", 32'h8, 1'b1, 5'd3, 1'b0);
        tick(); chk_out("up2", 32'h10, 1'b1, 5'd4, 1'b0);

        // 3. wrap in both directions
        load_valid = 1'b1; load_idx = 5'd31;
        tick(); chk_out("ld31", 32'h8000_0000, 1'b1, 5'd31, 1'b0);
        load_valid = 1'b0;
        tick(); chk_out("wrap_up", 32'h0000_0001, 1'b1, 5'd0, 1'b1);
        dir = 1'b1;
        tick(); chk_out("wrap_dn", 32'h8000_0000, 1'b1, 5'd31, 1'b1);
        tick(); chk_out("dn1", 32'h4000_0000, 1'b1, 5'd30, 1'b0);
        step = 1'b0;
        tick(); chk_out("nostep", 32'h4000_0000, 1'b1, 5'd30, 1'b0);

        // 4. stall: hold word, refuse load, then advance on release
        step = 1'b1; dir = 1'b0; dout_ready = 1'b0; load_valid = 1'b1; load_idx = 5'd5;
        #1; chk("stall.load_ready", 32'(load_ready), 32'd0);
        tick(); chk_out("stall1", 32'h4000_0000, 1'b1, 5'd30, 1'b0);
        tick(); chk_out("stall2", 32'h4000_0000, 1'b1, 5'd30, 1'b0);
        dout_ready = 1'b1; load_valid = 1'b0;
        #1; chk("rel.load_ready", 32'(load_ready), 32'd1);
        tick(); chk_out("rel", 32'h8000_0000, 1'b1, 5'd31, 1'b0);

        // 5. stop beats a simultaneous load
        stop = 1'b1; load_valid = 1'b1; load_idx = 5'd3;
        tick(); chk_out("stop", 32'h0, 1'b0, 5'd0, 1'b0);
        stop = 1'b0; load_valid = 1'b0;
        tick(); chk_out("idle", 32'h0, 1'b0, 5'd0, 1'b0);

        // 6. reset mid-walk at 0x100, then reload 0
        load_valid = 1'b1; load_idx = 5'd5;
        tick(); chk_out("ld5", 32'h20, 1'b1, 5'd5, 1'b0);
        load_valid = 1'b0;
        tick(); tick(); tick();
        chk_out("walk8", 32'h100, 1'b1, 5'd8, 1'b0);
        resetn = 1'b0;
        tick(); chk_out("midrst", 32'h0, 1'b0, 5'd0, 1'b0);
        resetn = 1'b1; load_valid = 1'b1; load_idx = 5'd0;
        tick(); chk_out("ld0", 32'h1, 1'b1, 5'd0, 1'b0);
        load_valid = 1'b0; dir = 1'b1;
        tick(); chk_out("wrap_dn2", 32'h8000_0000, 1'b1, 5'd31, 1'b1);
`ifdef ONEHOT_WALKER_SELFCHECK_EN
        chk("end.err", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_onehot_walker
